// File: rtl/mux41_arb_pkg.sv
// Shared types and constants for the 4:1 round-robin mux arbiter.
// Used by rr_pick4 and mux41_rr_arbiter.
package mux41_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } arb_state_t;

    localparam int NUM_SRC = 4;

    localparam logic [1:0] SEL_IN1 = 2'b00;
    localparam logic [1:0] SEL_IN2 = 2'b01;
    localparam logic [1:0] SEL_IN3 = 2'b10;
    localparam logic [1:0] SEL_IN4 = 2'b11;

endpackage

// File: rtl/mux41_rr_arbiter_pick.sv
// rr_pick4: combinational round-robin picker over four requests.
// The search starts at ptr and wraps, so the lowest index at or after ptr wins.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] winner,
    output logic       any_req
);

    logic [7:0] doubled;
    logic [3:0] rotated;

    // Doubling the vector lets a plain part-select perform the rotation by ptr.
    assign doubled = {req, req};
    assign rotated = doubled[ptr +: 4];
    assign any_req = |req;

    always_comb begin
        winner = ptr;
        for (int k = 3; k >= 0; k--) begin
            if (rotated[k]) begin
                winner = ptr + 2'(k);
            end
        end
    end

endmodule

// File: rtl/mux41_rr_arbiter.sv
// Round-robin arbiter/sequencer for the 4:1 two-bit mux, with bursts of up to BURST beats.
// Optional per-source accepted-beat counters are enabled with MUX_ARB_STATS_EN.
module mux41_rr_arbiter
    import mux41_arb_pkg::*;
#(
    parameter int DW    = 2,
    parameter int BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    req,
    input  logic [DW-1:0] in1,
    input  logic [DW-1:0] in2,
    input  logic [DW-1:0] in3,
    input  logic [DW-1:0] in4,
    input  logic          out_ready,
    output logic          s0,
    output logic          s1,
    output logic [3:0]    grant,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          busy
`ifdef MUX_ARB_STATS_EN
    ,
    output logic [31:0]   grant_cnt
`endif
);

    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST - 1);

    arb_state_t    state;
    logic [1:0]    ptr;
    logic [1:0]    sel;
    logic [1:0]    win;
    logic          any_req;
    logic [CW-1:0] cnt;
    logic [DW-1:0] src [NUM_SRC];
    logic          beat;
    logic          rel_now;

    assign src[0] = in1;
    assign src[1] = in2;
    assign src[2] = in3;
    assign src[3] = in4;

    assign s1 = sel[1];
    assign s0 = sel[0];

    rr_pick4 u_pick (
        .req     (req),
        .ptr     (ptr),
        .winner  (win),
        .any_req (any_req)
    );

    // The owner is whatever sel points at while serving.
    assign beat    = (state == SERVE) && out_valid && out_ready;
    assign rel_now = beat && ((cnt == LAST_BEAT) || !req[sel]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= SEL_IN1;
            sel       <= SEL_IN1;
            grant     <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state     <= SERVE;
                        grant     <= 4'b0001 << win;
                        sel       <= win;
                        out_data  <= src[win];
                        out_valid <= 1'b1;
                        cnt       <= '0;
                        busy      <= 1'b1;
                    end
                end
                SERVE: begin
                    if (rel_now) begin
                        // s1/s0 deliberately keep the last owner through the bubble.
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        grant     <= '0;
                        ptr       <= sel + 2'd1;
                        busy      <= 1'b0;
                    end else if (beat) begin
                        cnt      <= cnt + 1'b1;
                        out_data <= src[sel];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MUX_ARB_STATS_EN
    logic [7:0] stat [NUM_SRC];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                stat[i] <= '0;
            end
        end else if (beat && (stat[sel] != 8'hFF)) begin
            stat[sel] <= stat[sel] + 8'd1;
        end
    end

    assign grant_cnt = {stat[3], stat[2], stat[1], stat[0]};
`endif

endmodule

// File: tb/tb_mux41_rr_arbiter.sv
// Self-checking bench for mux41_rr_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_mux41_rr_arbiter;

    localparam int DW    = 2;
    localparam int BURST = 4;

    logic          clk;
    logic          rst;
    logic [3:0]    req;
    logic [DW-1:0] in1, in2, in3, in4;
    logic          out_ready;
    logic          s0, s1;
    logic [3:0]    grant;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          busy;
`ifdef MUX_ARB_STATS_EN
    logic [31:0]   grant_cnt;
`endif

    int n_compared = 0;
    int n_mismatched = 0;

    mux41_rr_arbiter #(.DW(DW), .BURST(BURST)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .in4       (in4),
        .out_ready (out_ready),
        .s0        (s0),
        .s1        (s1),
        .grant     (grant),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy)
`ifdef MUX_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then land just after the edge that consumed them.
    task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic rdy);
        rst       = r;
        req       = rq;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: owner index, beats presented in the current grant, rotation pointer.
    bit model_ok = 0;
    bit m_valid;
    int m_ptr, m_owner, m_last_sel, m_beats, m_data;
    int m_stat [4];
    int srcv [4];
    bit found;
    int idx;

    always @(posedge clk) begin
        srcv[0] = int'(in1);
        srcv[1] = int'(in2);
        srcv[2] = int'(in3);
        srcv[3] = int'(in4);
        if (rst === 1'b1) begin
            model_ok   = 1;
            m_valid    = 0;
            m_ptr      = 0;
            m_owner    = 0;
            m_last_sel = 0;
            m_beats    = 0;
            m_data     = 0;
            for (int i = 0; i < 4; i++) m_stat[i] = 0;
        end else if (model_ok) begin
            if (!m_valid) begin
                found = 0;
                for (int k = 0; k < 4; k++) begin
                    idx = (m_ptr + k) % 4;
                    if (!found && req[idx]) begin
                        found      = 1;
                        m_valid    = 1;
                        m_owner    = idx;
                        m_last_sel = idx;
                        m_beats    = 1;
                        m_data     = srcv[idx];
                    end
                end
            end else if (out_ready) begin
                if (m_stat[m_owner] < 255) m_stat[m_owner]++;
                if (m_beats == BURST || !req[m_owner]) begin
                    m_valid = 0;
                    m_ptr   = (m_owner + 1) % 4;
                end else begin
                    m_beats++;
                    m_data = srcv[m_owner];
                end
            end
        end
    end

    // Compare every cycle once the model has seen a reset.
    always @(negedge clk) begin
        if (model_ok) begin
            checkOutput("model out_valid", {31'b0, out_valid}, {31'b0, m_valid});
            checkOutput("model grant", {28'b0, grant}, m_valid ? (32'd1 << m_owner) : 32'd0);
            checkOutput("model sel", {30'b0, s1, s0}, m_last_sel);
            checkOutput("model busy", {31'b0, busy}, {31'b0, m_valid});
            checkOutput("model out_data", {30'b0, out_data}, m_data);
`ifdef MUX_ARB_STATS_EN
            checkOutput("model grant_cnt", grant_cnt,
                        {m_stat[3][7:0], m_stat[2][7:0], m_stat[1][7:0], m_stat[0][7:0]});
`endif
        end
    end

    initial begin
        rst = 1'b1; req = '0; out_ready = 1'b0;
        in1 = 2'b00; in2 = 2'b01; in3 = 2'b10; in4 = 2'b11;

        // Reset values
        applyStimulus(1, 4'b0000, 0);
        applyStimulus(1, 4'b0000, 0);
        checkOutput("reset out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("reset grant", {28'b0, grant}, 32'd0);
        checkOutput("reset sel", {30'b0, s1, s0}, 32'd0);
        checkOutput("reset busy", {31'b0, busy}, 32'd0);
        checkOutput("reset out_data", {30'b0, out_data}, 32'd0);

        // Full rotation: four beats per source, one bubble between owners
        for (int c = 1; c <= 21; c++) begin
            applyStimulus(0, 4'b1111, 1);
            checkOutput("rr valid", {31'b0, out_valid}, ((c - 1) % 5 != 4) ? 32'd1 : 32'd0);
            if ((c - 1) % 5 != 4) begin
                checkOutput("rr data", {30'b0, out_data}, ((c - 1) / 5) % 4);
                checkOutput("rr grant", {28'b0, grant}, 32'd1 << (((c - 1) / 5) % 4));
            end
        end

        // Backpressure mid-burst on in2
        applyStimulus(1, 4'b0000, 0);
        applyStimulus(0, 4'b0010, 1);
        applyStimulus(0, 4'b0010, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 4'b0010, 0);
            checkOutput("stall valid", {31'b0, out_valid}, 32'd1);
            checkOutput("stall data", {30'b0, out_data}, 32'd1);
            checkOutput("stall grant", {28'b0, grant}, 32'h2);
            checkOutput("stall sel", {30'b0, s1, s0}, 32'd1);
        end
        applyStimulus(0, 4'b0010, 1);
        checkOutput("post-stall beat3 valid", {31'b0, out_valid}, 32'd1);
        applyStimulus(0, 4'b0010, 1);
        checkOutput("post-stall beat4 valid", {31'b0, out_valid}, 32'd1);
        applyStimulus(0, 4'b0010, 1);
        checkOutput("burst end valid", {31'b0, out_valid}, 32'd0);

        // Early release, then pointer past in3 favours in4 over in1
        applyStimulus(1, 4'b0000, 0);
        applyStimulus(0, 4'b0100, 1);
        checkOutput("early grant", {28'b0, grant}, 32'h4);
        applyStimulus(0, 4'b0100, 1);
        checkOutput("early beat2 valid", {31'b0, out_valid}, 32'd1);
        applyStimulus(0, 4'b0000, 1);
        checkOutput("early release valid", {31'b0, out_valid}, 32'd0);
        checkOutput("early release grant", {28'b0, grant}, 32'd0);
        checkOutput("early release sel kept", {30'b0, s1, s0}, 32'd2);
        applyStimulus(0, 4'b1001, 1);
        checkOutput("ptr grant in4", {28'b0, grant}, 32'h8);
        checkOutput("ptr data in4", {30'b0, out_data}, 32'd3);

        // Reset mid-burst on in3
        applyStimulus(1, 4'b0000, 0);
        applyStimulus(0, 4'b0100, 1);
        applyStimulus(0, 4'b0100, 1);
        applyStimulus(1, 4'b0100, 1);
        checkOutput("midrst valid", {31'b0, out_valid}, 32'd0);
        checkOutput("midrst grant", {28'b0, grant}, 32'd0);
        checkOutput("midrst sel", {30'b0, s1, s0}, 32'd0);
        applyStimulus(0, 4'b1111, 1);
        checkOutput("after rst grant in1", {28'b0, grant}, 32'h1);

`ifdef MUX_ARB_STATS_EN
        // Two full rotations, then saturation on in1
        applyStimulus(1, 4'b0000, 0);
        for (int c = 0; c < 40; c++) applyStimulus(0, 4'b1111, 1);
        checkOutput("stats 2 rotations", grant_cnt, {8'd8, 8'd8, 8'd8, 8'd8});
        applyStimulus(1, 4'b0000, 0);
        for (int c = 0; c < 400; c++) applyStimulus(0, 4'b0001, 1);
        checkOutput("stats saturate", grant_cnt, {8'd0, 8'd0, 8'd0, 8'd255});
`endif

        // Randomized traffic
        applyStimulus(1, 4'b0000, 0);
        for (int c = 0; c < 3000; c++) begin
            in1 = 2'($urandom);
            in2 = 2'($urandom);
            in3 = 2'($urandom);
            in4 = 2'($urandom);
            applyStimulus(($urandom_range(0, 199) == 0),
                          ($urandom_range(0, 3) == 0) ? 4'($urandom) : req,
                          ($urandom_range(0, 3) != 0));
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
